// File: rtl/return_address_stack_if.sv
// Controller-facing bundle for the return address stack.
// master drives push/pop/err_clr; slave reports top and status.
interface return_address_stack_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int PTR_W      = 3
);
  logic                  push;
  logic                  pop;
  logic [ADDR_WIDTH-1:0] push_addr;
  logic                  err_clr;
  logic [ADDR_WIDTH-1:0] top_addr;
  logic [PTR_W:0]        count;
  logic                  empty;
  logic                  full;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output push, pop, push_addr, err_clr,
    input  top_addr, count, empty, full,
    input  overflow, underflow
  );

  modport slave (
    input  push, pop, push_addr, err_clr,
    output top_addr, count, empty, full,
    output overflow, underflow
  );
endinterface

// File: rtl/return_address_stack.sv
// Circular call/return stack with zero-latency top read,
// occupancy tracking and sticky overflow/underflow flags.
module return_address_stack #(
  parameter int ADDR_WIDTH = 12,
  parameter int DEPTH      = 8,
  parameter int PTR_W      = 3
) (
  input  logic clk,
  input  logic rst,
  return_address_stack_if.slave ras
);
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

  logic [ADDR_WIDTH-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;

  logic [PTR_W-1:0]      top_ptr;
  logic                  nonempty;
  logic                  is_full;
  logic                  mem_we;
  logic [PTR_W-1:0]      mem_wa;
  logic                  ovf_set;
  logic                  udf_set;
  logic                  op_swap;
  logic                  op_push;
  logic                  op_pop;
  logic                  op_pop_e;

  assign top_ptr  = wr_ptr_q - PTR_W'(1);
  assign nonempty = (count_q != '0);
  assign is_full  = (count_q == DEPTH_C);

  // Mutually exclusive decode of the four update cases
  assign op_swap  = ras.push & ras.pop & nonempty;
  assign op_push  = ras.push & ~op_swap;
  assign op_pop   = ras.pop & ~ras.push & nonempty;
  assign op_pop_e = ras.pop & ~ras.push & ~nonempty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    mem_we   = 1'b0;
    mem_wa   = wr_ptr_q;
    ovf_set  = 1'b0;
    udf_set  = 1'b0;
    unique case (1'b1)
      op_swap: begin
        mem_we = 1'b1;
        mem_wa = top_ptr;
      end
      op_push: begin
        mem_we   = 1'b1;
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (is_full) ovf_set = 1'b1;
        else count_d = count_q + (PTR_W+1)'(1);
      end
      op_pop: begin
        wr_ptr_d = wr_ptr_q - PTR_W'(1);
        count_d  = count_q - (PTR_W+1)'(1);
      end
      op_pop_e: udf_set = 1'b1;
      default: ;
    endcase
    // A new error event beats a coincident clear
    ovf_d = ovf_set | (ovf_q & ~ras.err_clr);
    udf_d = udf_set | (udf_q & ~ras.err_clr);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_wa] <= ras.push_addr;
  end

  assign ras.top_addr  = nonempty ? mem_q[top_ptr] : '0;
  assign ras.count     = count_q;
  assign ras.empty     = ~nonempty;
  assign ras.full      = is_full;
  assign ras.overflow  = ovf_q;
  assign ras.underflow = udf_q;
endmodule

// File: tb/tb_return_address_stack.sv
// Directed bench for return_address_stack: LIFO, overflow,
// underflow, push+pop swap, wrap against a queue model, async reset.
module tb_return_address_stack;
  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;

  return_address_stack_if #(.ADDR_WIDTH(12), .PTR_W(3)) ras_if ();

  return_address_stack #(
    .ADDR_WIDTH(12),
    .DEPTH(8),
    .PTR_W(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ras(ras_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ras_if.push      = 1'b0;
    ras_if.pop       = 1'b0;
    ras_if.err_clr   = 1'b0;
    ras_if.push_addr = '0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b0;
    #3;
    rst = 1'b1;
    cyc();
  endtask

  task automatic do_push(input logic [11:0] a);
    ras_if.push      = 1'b1;
    ras_if.pop       = 1'b0;
    ras_if.push_addr = a;
    cyc();
    idle();
  endtask

  task automatic do_pop();
    ras_if.push = 1'b0;
    ras_if.pop  = 1'b1;
    cyc();
    idle();
  endtask

  task automatic test_reset();
    idle();
    rst              = 1'b0;
    ras_if.push      = 1'b1;
    ras_if.push_addr = 12'h005;
    cyc();
    cyc();
    n_chk++;
    if (ras_if.count !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_count got %0d exp 0", ras_if.count);
    end
    n_chk++;
    if (ras_if.empty !== 1'b1 || ras_if.full !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_status got e=%b f=%b exp e=1 f=0",
               ras_if.empty, ras_if.full);
    end
    n_chk++;
    if (ras_if.top_addr !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_top got %h exp 000", ras_if.top_addr);
    end
    n_chk++;
    if (ras_if.overflow !== 1'b0 || ras_if.underflow !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags got o=%b u=%b exp 0 0",
               ras_if.overflow, ras_if.underflow);
    end
    idle();
    rst = 1'b1;
    cyc();
  endtask

  task automatic test_lifo();
    logic [11:0] exp_top [3];
    exp_top = '{12'h020, 12'h010, 12'h000};
    do_push(12'h010);
    do_push(12'h020);
    do_push(12'h030);
    n_chk++;
    if (ras_if.top_addr !== 12'h030 || ras_if.count !== 4'd3) begin
      n_fail++;
      $display("FAIL lifo_fill got top=%h cnt=%0d exp 030 3",
               ras_if.top_addr, ras_if.count);
    end
    for (int i = 0; i < 3; i++) begin
      do_pop();
      n_chk++;
      if (ras_if.top_addr !== exp_top[i]) begin
        n_fail++;
        $display("FAIL lifo_pop%0d got %h exp %h",
                 i, ras_if.top_addr, exp_top[i]);
      end
    end
    n_chk++;
    if (ras_if.empty !== 1'b1 || ras_if.underflow !== 1'b0) begin
      n_fail++;
      $display("FAIL lifo_empty got e=%b u=%b exp 1 0",
               ras_if.empty, ras_if.underflow);
    end
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 8; i++) do_push(12'(i));
    n_chk++;
    if (ras_if.full !== 1'b1 || ras_if.overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_at8 got f=%b o=%b exp 1 0",
               ras_if.full, ras_if.overflow);
    end
    do_push(12'd9);
    n_chk++;
    if (ras_if.full !== 1'b1 || ras_if.count !== 4'd8 ||
        ras_if.overflow !== 1'b1 || ras_if.top_addr !== 12'd9) begin
      n_fail++;
      $display("FAIL ovf_at9 got f=%b c=%0d o=%b t=%0d exp 1 8 1 9",
               ras_if.full, ras_if.count, ras_if.overflow,
               ras_if.top_addr);
    end
    for (int k = 1; k <= 8; k++) begin
      do_pop();
      n_chk++;
      if (k < 8 && ras_if.top_addr !== 12'(9 - k)) begin
        n_fail++;
        $display("FAIL ovf_pop%0d got %0d exp %0d",
                 k, ras_if.top_addr, 9 - k);
      end else if (k == 8 &&
                   (ras_if.top_addr !== 12'd0 || ras_if.empty !== 1'b1)) begin
        n_fail++;
        $display("FAIL ovf_drain got t=%0d e=%b exp 0 1",
                 ras_if.top_addr, ras_if.empty);
      end
    end
    n_chk++;
    if (ras_if.overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_sticky got %b exp 1", ras_if.overflow);
    end
    ras_if.err_clr = 1'b1;
    cyc();
    idle();
    n_chk++;
    if (ras_if.overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_clr got %b exp 0", ras_if.overflow);
    end
  endtask

  task automatic test_underflow();
    do_pop();
    n_chk++;
    if (ras_if.underflow !== 1'b1 || ras_if.count !== 4'd0) begin
      n_fail++;
      $display("FAIL udf_set got u=%b c=%0d exp 1 0",
               ras_if.underflow, ras_if.count);
    end
    ras_if.pop     = 1'b1;
    ras_if.err_clr = 1'b1;
    cyc();
    idle();
    n_chk++;
    if (ras_if.underflow !== 1'b1) begin
      n_fail++;
      $display("FAIL udf_set_wins got %b exp 1", ras_if.underflow);
    end
    ras_if.err_clr = 1'b1;
    cyc();
    idle();
    n_chk++;
    if (ras_if.underflow !== 1'b0) begin
      n_fail++;
      $display("FAIL udf_clr got %b exp 0", ras_if.underflow);
    end
  endtask

  task automatic test_push_pop();
    ras_if.push      = 1'b1;
    ras_if.pop       = 1'b1;
    ras_if.push_addr = 12'h0AB;
    cyc();
    idle();
    n_chk++;
    if (ras_if.count !== 4'd1 || ras_if.top_addr !== 12'h0AB ||
        ras_if.underflow !== 1'b0) begin
      n_fail++;
      $display("FAIL pp_empty got c=%0d t=%h u=%b exp 1 0ab 0",
               ras_if.count, ras_if.top_addr, ras_if.underflow);
    end
    do_pop();
    do_push(12'h100);
    do_push(12'h200);
    ras_if.push      = 1'b1;
    ras_if.pop       = 1'b1;
    ras_if.push_addr = 12'h2AA;
    cyc();
    idle();
    n_chk++;
    if (ras_if.count !== 4'd2 || ras_if.top_addr !== 12'h2AA) begin
      n_fail++;
      $display("FAIL pp_swap got c=%0d t=%h exp 2 2aa",
               ras_if.count, ras_if.top_addr);
    end
    do_pop();
    n_chk++;
    if (ras_if.count !== 4'd1 || ras_if.top_addr !== 12'h100) begin
      n_fail++;
      $display("FAIL pp_after got c=%0d t=%h exp 1 100",
               ras_if.count, ras_if.top_addr);
    end
  endtask

  task automatic test_wrap();
    // 0 = pop, 1 = push, 2 = push+pop
    int          ops [20];
    logic [11:0] q [$];
    logic [11:0] a;
    logic [11:0] exp_top;
    ops = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1,
            0, 2, 0, 0, 1, 2, 0, 0, 0, 0};
    do_reset();
    for (int i = 0; i < 20; i++) begin
      a = 12'h300 + 12'(i);
      ras_if.push      = (ops[i] != 0);
      ras_if.pop       = (ops[i] != 1);
      ras_if.push_addr = a;
      cyc();
      idle();
      if (ops[i] == 1) begin
        if (q.size() == 8) void'(q.pop_front());
        q.push_back(a);
      end else if (ops[i] == 2) begin
        if (q.size() > 0) q[q.size()-1] = a;
        else q.push_back(a);
      end else if (q.size() > 0) begin
        void'(q.pop_back());
      end
      exp_top = (q.size() > 0) ? q[q.size()-1] : 12'h000;
      n_chk++;
      if (ras_if.top_addr !== exp_top ||
          ras_if.count !== 4'(q.size())) begin
        n_fail++;
        $display("FAIL wrap_step%0d got t=%h c=%0d exp %h %0d",
                 i, ras_if.top_addr, ras_if.count, exp_top, q.size());
      end
    end
  endtask

  task automatic test_async_reset();
    do_push(12'h011);
    do_push(12'h022);
    do_push(12'h033);
    ras_if.push      = 1'b1;
    ras_if.push_addr = 12'h044;
    rst              = 1'b0;
    #1;
    n_chk++;
    if (ras_if.empty !== 1'b1 || ras_if.count !== 4'd0 ||
        ras_if.top_addr !== 12'h000) begin
      n_fail++;
      $display("FAIL async_rst got e=%b c=%0d t=%h exp 1 0 000",
               ras_if.empty, ras_if.count, ras_if.top_addr);
    end
    #1;
    rst              = 1'b1;
    ras_if.push_addr = 12'h077;
    cyc();
    idle();
    n_chk++;
    if (ras_if.count !== 4'd1 || ras_if.top_addr !== 12'h077) begin
      n_fail++;
      $display("FAIL post_rst got c=%0d t=%h exp 1 077",
               ras_if.count, ras_if.top_addr);
    end
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst    = 1'b0;
    idle();
    test_reset();
    test_lifo();
    test_overflow();
    test_underflow();
    test_push_pop();
    test_wrap();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
